// File: rtl/cmd_parser_pkg.sv
// Shared types and constants for the command/register frame parser.
package cmd_parser_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2,
        ST_CHK  = 2'd3
    } state_t;

    localparam logic [1:0] ERR_NONE     = 2'b00;
    localparam logic [1:0] ERR_BAD_ADDR = 2'b01;
    localparam logic [1:0] ERR_CHECKSUM = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT  = 2'b11;

    localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

endpackage

// File: rtl/rx_frame_timer.sv
// Inter-byte timeout counter: counts cycles without a byte while a frame is open.
// TIMEOUT_CYC = 0 never expires.
module rx_frame_timer #(
    parameter int TIMEOUT_CYC = 500000
) (
    input  logic CLK,
    input  logic RST,
    input  logic clear,
    input  logic run,
    output logic expired
);

    localparam int CW   = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam int LAST = (TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0;

    logic [CW-1:0] cnt;

    // Saturates at the terminal value; the parser leaves the frame on expiry anyway.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt <= '0;
        end else if (clear || !run) begin
            cnt <= '0;
        end else if (cnt != CW'(LAST)) begin
            cnt <= cnt + 1'b1;
        end
    end

    // A byte arriving on the terminal cycle masks expiry.
    assign expired = (TIMEOUT_CYC != 0) && run && !clear && (cnt == CW'(LAST));

endmodule

// File: rtl/cmd_reg_parser.sv
// UART frame parser: SYNC, ADDR, data bytes (MSB first) [, CHK] -> register file write.
// Define CMD_PARSER_CHECKSUM_EN to require a trailing XOR checksum byte.
module cmd_reg_parser
    import cmd_parser_pkg::*;
#(
    parameter int         NUM_REGS    = 3,
    parameter int         REG_BYTES   = 3,
    parameter logic [7:0] SYNC_BYTE   = DEFAULT_SYNC_BYTE,
    parameter int         TIMEOUT_CYC = 500000
) (
    input  logic                            CLK,
    input  logic                            RST,
    input  logic                            RX_Done_Sig,
    input  logic [7:0]                      RX_Data,
    output logic                            RX_En_Sig,
    output logic [NUM_REGS*REG_BYTES*8-1:0] reg_flat,
    output logic                            upd_sig,
    output logic [7:0]                      upd_addr,
    output logic                            err_sig,
    output logic [1:0]                      err_code,
    output logic [1:0]                      dbg_state
);

    localparam int         RW        = REG_BYTES * 8;
    localparam logic [2:0] LAST_BYTE = 3'(REG_BYTES - 1);

    state_t        state;
    logic [7:0]    addr_q;
    logic [RW-1:0] shadow;
    logic [RW-1:0] shadow_nxt;
    logic [RW-1:0] commit_val;
    logic [2:0]    byte_cnt;
    logic          timeout;

    assign shadow_nxt = RW'({shadow, RX_Data});
    assign dbg_state  = state;

`ifdef CMD_PARSER_CHECKSUM_EN
    logic [7:0] chk_q;
    assign commit_val = shadow;
`else
    assign commit_val = shadow_nxt;
`endif

    rx_frame_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timer (
        .CLK     (CLK),
        .RST     (RST),
        .clear   (RX_Done_Sig),
        .run     (state != ST_IDLE),
        .expired (timeout)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= ST_IDLE;
            addr_q    <= '0;
            shadow    <= '0;
            byte_cnt  <= '0;
            reg_flat  <= '0;
            upd_sig   <= 1'b0;
            upd_addr  <= '0;
            err_sig   <= 1'b0;
            err_code  <= ERR_NONE;
            RX_En_Sig <= 1'b0;
`ifdef CMD_PARSER_CHECKSUM_EN
            chk_q     <= '0;
`endif
        end else begin
            RX_En_Sig <= 1'b1;
            upd_sig   <= 1'b0;
            err_sig   <= 1'b0;
            if (RX_Done_Sig) begin
                case (state)
                    ST_IDLE: begin
                        if (RX_Data == SYNC_BYTE) state <= ST_ADDR;
                    end
                    ST_ADDR: begin
                        if (int'(RX_Data) >= NUM_REGS) begin
                            state    <= ST_IDLE;
                            err_sig  <= 1'b1;
                            err_code <= ERR_BAD_ADDR;
                        end else begin
                            addr_q   <= RX_Data;
                            shadow   <= '0;
                            byte_cnt <= '0;
`ifdef CMD_PARSER_CHECKSUM_EN
                            chk_q    <= RX_Data;
`endif
                            state    <= ST_DATA;
                        end
                    end
                    ST_DATA: begin
                        // SYNC_BYTE values here are payload, not a new frame start.
                        shadow   <= shadow_nxt;
                        byte_cnt <= byte_cnt + 1'b1;
`ifdef CMD_PARSER_CHECKSUM_EN
                        chk_q    <= chk_q ^ RX_Data;
                        if (byte_cnt == LAST_BYTE) state <= ST_CHK;
`else
                        if (byte_cnt == LAST_BYTE) begin
                            state    <= ST_IDLE;
                            upd_sig  <= 1'b1;
                            upd_addr <= addr_q;
                            for (int k = 0; k < NUM_REGS; k++) begin
                                if (addr_q == 8'(k)) reg_flat[k*RW +: RW] <= commit_val;
                            end
                        end
`endif
                    end
`ifdef CMD_PARSER_CHECKSUM_EN
                    ST_CHK: begin
                        state <= ST_IDLE;
                        if (RX_Data == chk_q) begin
                            upd_sig  <= 1'b1;
                            upd_addr <= addr_q;
                            for (int k = 0; k < NUM_REGS; k++) begin
                                if (addr_q == 8'(k)) reg_flat[k*RW +: RW] <= commit_val;
                            end
                        end else begin
                            err_sig  <= 1'b1;
                            err_code <= ERR_CHECKSUM;
                        end
                    end
`endif
                    default: state <= ST_IDLE;
                endcase
            end else if (timeout) begin
                state    <= ST_IDLE;
                err_sig  <= 1'b1;
                err_code <= ERR_TIMEOUT;
            end
        end
    end

endmodule
